// File: rtl/mont_decode_p_pkg.sv
// rtl/mont_decode_p_pkg.sv - shared modulus defines, constants and FSM encoding for mont_decode_p
//
// Purpose: holds the field modulus (`Modulus), its width (`R_Bits), the
// Montgomery radix exponent, the 3p constant used by the radix-4 engine, and
// the state encoding of the decode FSM.
// Optional feature macro: MONT_DECODE_RADIX4_EN (enables MONT_P3).

`ifndef Modulus
`define Modulus 8'd251
`endif

`ifndef R_Bits
`define R_Bits 8
`endif

package mont_decode_p_pkg;

  localparam int MONT_R_LOG = 128;

  localparam logic [`R_Bits-1:0] MONT_P = `R_Bits'(`Modulus);

`ifdef MONT_DECODE_RADIX4_EN
  // 3p is built as p + 2p so it never depends on 32-bit integer arithmetic.
  localparam logic [`R_Bits+1:0] MONT_P3 = {2'b00, MONT_P} + {1'b0, MONT_P, 1'b0};
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mont_state_e;

endpackage

// File: rtl/mont_decode_p_cond_sub.sv
// rtl/mont_decode_p_cond_sub.sv - conditional subtraction t >= p ? t-p : t
//
// Purpose: final reduction step shared with add/sub style field units.
// Ports:
//   t_i  in  W+1  value known to be < 2p
//   r_o  out W    fully reduced result, 0 <= r_o < p

module cond_sub_p #(
  parameter int          W = 8,
  parameter logic [W-1:0] P = '0
) (
  input  logic [W:0]   t_i,
  output logic [W-1:0] r_o
);

  logic [W:0] diff;
  logic       unused_msb;

  assign diff       = t_i - {1'b0, P};
  // When t_i >= p the difference is below p, so its top bit is always zero.
  assign unused_msb = diff[W];
  assign r_o        = (t_i >= {1'b0, P}) ? diff[W-1:0] : t_i[W-1:0];

endmodule

// File: rtl/mont_decode_p.sv
// rtl/mont_decode_p.sv - bit-serial Montgomery reduction r = x * 2^-R_LOG mod p
//
// Purpose: converts a field element out of the Montgomery domain with a
// fixed-latency iteration engine and valid/ready handshakes on both sides.
// Optional feature macro: MONT_DECODE_RADIX4_EN (two bits retired per cycle).
// Ports:
//   clk        in  1  clock, all state on posedge
//   reset      in  1  synchronous active-high reset
//   in_valid   in  1  x is presented
//   in_ready   out 1  block idle and able to accept x
//   x          in  W  Montgomery-domain value
//   out_valid  out 1  r is valid, held until accepted
//   out_ready  in  1  consumer accepts r
//   r          out W  x * R^-1 mod p, fully reduced

module mont_decode_p
  import mont_decode_p_pkg::*;
#(
  parameter int R_LOG = MONT_R_LOG,
  parameter int W     = `R_Bits
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] r
);

  localparam int CNT_W = $clog2(R_LOG) + 1;
`ifdef MONT_DECODE_RADIX4_EN
  localparam int STEPS = R_LOG / 2;
`else
  localparam int STEPS = R_LOG;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);
  localparam logic [W-1:0]     P    = W'(MONT_P);

  mont_state_e      state_q, state_d;
  logic [W:0]       t_q, t_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     r_q, r_d;

  logic [W:0]       t_step;
  logic [W-1:0]     r_fix;

`ifdef MONT_DECODE_RADIX4_EN
  localparam logic [W+1:0] P3 = (W+2)'(MONT_P3);

  logic [1:0]   tp;
  logic [1:0]   q;
  logic [W+2:0] qp;
  logic [W+2:0] sum4;
  logic [1:0]   unused_low;

  // q makes t + q*p divisible by 4; p^-1 == p (mod 4) for odd p.
  assign tp = t_q[1:0] * P[1:0];
  assign q  = 2'd0 - tp;

  always_comb begin
    qp = '0;
    case (q)
      2'd1:    qp = {3'b000, P};
      2'd2:    qp = {2'b00, P, 1'b0};
      2'd3:    qp = {1'b0, P3};
      default: qp = '0;
    endcase
  end

  assign sum4       = {2'b00, t_q} + qp;
  assign t_step     = sum4[W+2:2];
  assign unused_low = sum4[1:0];
`else
  logic [W+1:0] sum2;
  logic         unused_low;

  // Adding p when t is odd makes the sum even, so the shift is exact.
  assign sum2       = {1'b0, t_q} + (t_q[0] ? {2'b00, P} : '0);
  assign t_step     = sum2[W+1:1];
  assign unused_low = sum2[0];
`endif

  cond_sub_p #(
    .W (W),
    .P (P)
  ) u_cond_sub (
    .t_i (t_q),
    .r_o (r_fix)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          t_d     = {1'b0, x};
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        t_d   = t_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        r_d     = r_fix;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign r         = r_q;

endmodule

// File: tb/tb_mont_decode_p.sv
// tb/tb_mont_decode_p.sv - self-checking bench for mont_decode_p (p = 251, W = 8, R = 2^128)

module tb_mont_decode_p;

`ifdef MONT_DECODE_RADIX4_EN
  localparam int LAT = 128 / 2 + 1;
`else
  localparam int LAT = 128 + 1;
`endif
  localparam int PMOD = 251;

  typedef struct {
    logic [7:0] x;
    logic [7:0] r;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mont_decode_p dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called #1 after the accept edge; counts edges until out_valid is seen.
  task automatic wait_result(output logic [7:0] rv, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rv = r;
  endtask

  task automatic do_op(input logic [7:0] xv, output logic [7:0] rv, output int lat);
    @(negedge clk);
    x        = xv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x        = 8'h5A;
    wait_result(rv, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[10];
    logic [7:0] rv;
    int         lat;
    int         rm;
    logic [31:0] seed;

    // Hand-derived: 2^128 mod 251 = 243, its inverse mod 251 = 94.
    vecs[0] = '{x: 8'd0,   r: 8'd0};
    vecs[1] = '{x: 8'd1,   r: 8'd94};
    vecs[2] = '{x: 8'd243, r: 8'd1};
    vecs[3] = '{x: 8'd250, r: 8'd157};
    vecs[4] = '{x: 8'd251, r: 8'd0};
    vecs[5] = '{x: 8'd255, r: 8'd125};
    vecs[6] = '{x: 8'd2,   r: 8'd188};
    vecs[7] = '{x: 8'd3,   r: 8'd31};
    vecs[8] = '{x: 8'd100, r: 8'd113};
    vecs[9] = '{x: 8'd128, r: 8'd235};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_r", r, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].x, rv, lat);
      chk($sformatf("vec%0d_r", i), rv, vecs[i].r);
      chk($sformatf("vec%0d_latency", i), lat, LAT);
    end

    // Backpressure: result must hold, input must be refused.
    out_ready = 1'b0;
    @(negedge clk);
    x        = 8'd100;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(rv, lat);
    chk("bp_r", rv, 113);
    chk("bp_latency", lat, LAT);
    in_valid = 1'b1;
    x        = 8'd5;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_r", r, 113);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("bp_next_accept", in_ready, 0);
    in_valid = 1'b0;
    wait_result(rv, lat);
    chk("bp_next_r", rv, 219);
    chk("bp_next_latency", lat, LAT);
    @(posedge clk);
    #1;

    // Reset in the middle of RUN with in_valid still asserted.
    @(negedge clk);
    x        = 8'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    x = 8'd7;
    repeat (49) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_r", r, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_fresh_accept", in_ready, 0);
    in_valid = 1'b0;
    wait_result(rv, lat);
    chk("abort_fresh_r", rv, 156);
    chk("abort_fresh_latency", lat, LAT);
    @(posedge clk);
    #1;

    // Random sweep checked against r * R == x (mod p), with R mod p computed by doubling.
    rm = 1;
    for (int i = 0; i < 128; i++) rm = (rm * 2) % PMOD;
    seed = 32'h1234_5678;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] xv;
      seed = seed * 32'd1103515245 + 32'd12345;
      xv   = seed[23:16];
      do_op(xv, rv, lat);
      chk("rand_congruence", (int'(rv) * rm) % PMOD, int'(xv) % PMOD);
      chk("rand_reduced", (int'(rv) < PMOD) ? 1 : 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mont_decode_p.md
# mont_decode_p

Converts a field element out of the Montgomery domain, computing r = x·R⁻¹ mod p with R = 2^R_LOG and p = `Modulus. It is the exit path matching the Montgomery-domain arithmetic (mont_mul_p, mont_invert_p, add/sub units). Coordinates leave the EC datapath through this block before output. It is a bit-serial Montgomery reduction with a valid/ready handshake on both sides and a single fixed-latency iteration engine.

## Interface
Parameters:
- R_LOG, 128, log2 of the Montgomery radix R; must satisfy `R_Bits ≤ R_LOG; R_LOG even when radix-4 is compiled in.
- W, `R_Bits, operand/result width.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- in_valid  in  1  x is presented.
- in_ready  out  1  block can accept x (high only in IDLE).
- x  in  W  Montgomery-domain value, any value < 2^W.
- out_valid  out  1  r is valid; held until accepted.
- out_ready  in  1  consumer accepts r.
- r  out  W  x·R⁻¹ mod p, fully reduced (0 ≤ r < p).

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: t ← {1'b0,x}, cnt ← 0, go RUN.
- RUN (radix-2): each cycle t ← (t + t[0]·p) >> 1 and cnt ← cnt+1. After the R_LOG-th update, go FIX.
- Width: t is W+1 bits; the sum t+p is W+2 bits before the shift. Invariant t < max(x, p) + 1. Because W ≤ R_LOG, the final t ≤ p.
- FIX: r_reg ← (t ≥ p) ? t−p : t; go DONE.
- DONE: out_valid=1, r=r_reg. On out_ready go IDLE. r and out_valid are stable while out_ready is low.
- No input is accepted in RUN/FIX/DONE. x is sampled only on the accept edge, so it may change afterwards.
- Reset: state←IDLE, out_valid=0, in_ready=1, r=0, t=0, cnt=0. Reset mid-RUN/FIX/DONE abandons the operation; no out_valid pulse follows.
- Reset has priority over any handshake in the same cycle.

## Timing
- Accept edge = edge 0. RUN occupies edges 1..R_LOG, or 1..R_LOG/2 with radix-4. FIX is the next edge.
- out_valid is high from edge R_LOG+1 (radix-2) or R_LOG/2+1 (radix-4).
- Out handshake at edge n → IDLE at n; in_ready high from n; the next accept is possible at edge n+1.
- Throughput with out_ready tied high: one result per R_LOG+3 cycles (radix-2).
- in_ready and out_valid are registered-state decodes only; there is no combinational path from in_valid/out_ready.

## Configuration
- MONT_DECODE_RADIX4_EN defined: RUN retires 2 bits per cycle.
  - q = (−t·p) mod 4 = (−t[1:0]·p[1:0]) mod 4, since p⁻¹ ≡ p mod 4.
  - t ← (t + q·p) >> 2, using constant 3p. t widens to W+3 bits internally.
  - RUN lasts R_LOG/2 cycles; results are identical to radix-2.
- Undefined: radix-2 as above; no 3p constant and no 2-bit quotient logic.

## Structure
- Shared defines/package: `Modulus, `R_Bits, MONT_R_LOG (=128), MONT_P3 (3·`Modulus, radix-4 only), and a state encoding localparam set.
- One natural sub-module: cond_sub_p (combinational t ≥ p ? t−p : t, W+1→W). It is reusable by add_p_p-style units.
- Counter is $clog2(R_LOG)+1 bits.

## Test plan
- x=0, out_ready=1 → r=0; out_valid rises exactly R_LOG+1 cycles after accept (R_LOG/2+1 with radix-4).
- x = R mod p (Montgomery one) → r=1. x=1 → r = R⁻¹ mod p, matching mont_mul_p(1,1) after domain adjustment.
- Hundreds of random x < 2^W → r == x·R⁻¹ mod p from the bench model. Include x = p−1, x = p, and x = 2^W−1 (exercises FIX with t==p).
- Backpressure: out_ready low for 20 cycles → r/out_valid stable, in_ready=0, a new in_valid is ignored. Raising out_ready → in_ready=1 the same cycle, and the next x is accepted on the following edge.
- Reset asserted at RUN cycle 50 with in_valid held high → IDLE next edge, out_valid never pulses for the aborted op, and a fresh x is accepted on the first edge after reset drops.
- Build both with and without MONT_DECODE_RADIX4_EN, using the same random vector set → identical r sequences.
